// File: rtl/hid_key_events.sv
// hid_key_events
//   Turns successive HID keyboard snapshots into discrete press/release
//   events. Each accepted report is diffed against the previous one. Eight
//   modifier slots and four key slots are walked one per cycle: releases
//   first, then presses. Every changed key is queued in a small event FIFO.
//
// Ports
//   clk, resetn            USB-domain clock, asynchronous active-low reset
//   usb_type               device type from host (1 = keyboard)
//   usb_report             one-cycle strobe: new snapshot on key inputs
//   key_modifiers          modifier bits, bit i = usage 0xE0+i
//   key1..key4             usage codes, 0x00 = empty slot
//   ev_valid/ev_ready      event FIFO head handshake
//   ev_code/ev_press       head event usage and direction (1 = press)
//   busy                   compare engine not idle
//   report_dropped         pulse: report arrived while busy and was ignored
//   overflow               sticky: an event was lost to a full FIFO
module hid_key_events #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] usb_type,
  input  logic       usb_report,
  input  logic [7:0] key_modifiers,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] key4,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_press,
  output logic       busy,
  output logic       report_dropped,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REL, S_PRS, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      prev_mod_q, prev_mod_d, cur_mod_q, cur_mod_d;
  logic [3:0][7:0] prev_key_q, prev_key_d, cur_key_q, cur_key_d;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [8:0]      fifo_mem_q [FIFO_DEPTH];

  // Slot evaluation for the scan currently in progress
  logic [7:0]      src_mod, oth_mod;
  logic [3:0][7:0] src_key, oth_key;
  logic [7:0]      slot_code;
  logic            slot_present, slot_absent, slot_first;
  logic            push, push_press;
  logic            pop, full, wr_en;
  logic            prev_nonempty;

  always_comb begin
    // Release scan walks prev against cur; press scan walks cur against prev.
    if (state_q == S_PRS) begin
      src_mod = cur_mod_q;  src_key = cur_key_q;
      oth_mod = prev_mod_q; oth_key = prev_key_q;
    end else begin
      src_mod = prev_mod_q; src_key = prev_key_q;
      oth_mod = cur_mod_q;  oth_key = cur_key_q;
    end
    slot_code    = 8'h00;
    slot_present = 1'b0;
    slot_absent  = 1'b1;
    slot_first   = 1'b1;
    if (idx_q < 4'd8) begin
      slot_code    = 8'hE0 | {5'd0, idx_q[2:0]};
      slot_present = src_mod[idx_q[2:0]];
      slot_absent  = !oth_mod[idx_q[2:0]];
    end else begin
      slot_code    = src_key[idx_q[1:0]];
      slot_present = (slot_code != 8'h00);
      for (int i = 0; i < 4; i++) begin
        if (oth_key[i] == slot_code) slot_absent = 1'b0;
        // A code repeated in the snapshot only reports from its lowest slot.
        if (i < int'(idx_q[1:0]) && src_key[i] == slot_code) slot_first = 1'b0;
      end
    end
    push       = (state_q == S_REL || state_q == S_PRS) &&
                 slot_present && slot_absent && slot_first;
    push_press = (state_q == S_PRS);
  end

  assign prev_nonempty = (prev_mod_q != 8'h00) || (prev_key_q != '0);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    prev_mod_d     = prev_mod_q;
    prev_key_d     = prev_key_q;
    cur_mod_d      = cur_mod_q;
    cur_key_d      = cur_key_q;
    report_dropped = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (usb_report && usb_type == 2'd1 && key1 != 8'h01) begin
          cur_mod_d = key_modifiers;
          cur_key_d = {key4, key3, key2, key1};
          idx_d     = 4'd0;
          state_d   = S_REL;
        end else if (usb_type != 2'd1 && prev_nonempty) begin
          // Device gone or no longer a keyboard: release everything held.
          cur_mod_d = 8'h00;
          cur_key_d = '0;
          idx_d     = 4'd0;
          state_d   = S_REL;
        end
      end
      S_REL: begin
        if (idx_q == 4'd11) begin
          idx_d   = 4'd0;
          state_d = S_PRS;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_PRS: begin
        if (idx_q == 4'd11) state_d = S_COMMIT;
        else                idx_d   = idx_q + 4'd1;
      end
      default: begin
        prev_mod_d = cur_mod_q;
        prev_key_d = cur_key_q;
        state_d    = S_IDLE;
      end
    endcase
    if (state_q != S_IDLE && usb_report) report_dropped = 1'b1;
  end

  // Event FIFO: a push into a full FIFO is only accepted if a pop frees a slot.
  always_comb begin
    full       = (count_q == (AW+1)'(FIFO_DEPTH));
    pop        = ev_valid && ev_ready;
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      prev_mod_q <= 8'h00;
      prev_key_q <= '0;
      cur_mod_q  <= 8'h00;
      cur_key_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_mod_q <= prev_mod_d;
      prev_key_q <= prev_key_d;
      cur_mod_q  <= cur_mod_d;
      cur_key_q  <= cur_key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {push_press, slot_code};
  end

  assign ev_valid = (count_q != '0);
  assign ev_code  = ev_valid ? fifo_mem_q[rd_ptr_q][7:0] : 8'h00;
  assign ev_press = ev_valid ? fifo_mem_q[rd_ptr_q][8]   : 1'b0;
  assign busy     = (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: doc/hid_key_events.md
# hid_key_events

Converts the keyboard state snapshots produced by `usb_hid_host` into a stream of discrete key press/release events. It sits directly downstream of the HID host on the USB clock, alongside `hid_printer`. It compares each new keyboard report against the previous one and queues one event per changed key in a small FIFO. Consumers (UART, soft-CPU, keyboard emulators) pop events with a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  USB-domain clock (12 MHz in current boards).
- `resetn`  in  1  reset; asynchronous, active-low.
- `usb_type`  in  2  device type from host; 1 = keyboard.
- `usb_report`  in  1  one-cycle strobe: new report on key inputs.
- `key_modifiers`  in  8  HID modifier bits; bit i = usage 0xE0+i.
- `key1`..`key4`  in  8 each  HID usage codes; 0x00 = empty slot.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts head this cycle.
- `ev_code`  out  8  HID usage of head event.
- `ev_press`  out  1  1 = press, 0 = release.
- `busy`  out  1  compare engine not IDLE.
- `report_dropped`  out  1  one-cycle pulse: report ignored because busy.
- `overflow`  out  1  sticky: an event was lost to a full FIFO; cleared only by reset.

## Operation
- State: `prev` snapshot (8 modifier bits + 4 codes), `cur` snapshot, FSM IDLE → SCAN_REL → SCAN_PRS → COMMIT → IDLE.
- Slot order, both scans: index 0..7 = modifier bits 0..7 (codes 0xE0..0xE7), 8..11 = key1..key4.
- IDLE, `usb_report`=1, `usb_type`=1, `key1`≠0x01: latch inputs into `cur`, go SCAN_REL with index 0.
- `key1`=0x01 (ErrorRollOver): report ignored entirely; no state change.
- IDLE, `usb_type`≠1 and `prev` non-empty (disconnect/type change): load `cur` = all-zero, go SCAN_REL (release-all).
- SCAN_REL: one slot per cycle. Push release of `prev` slot if it is present (bit set / code ≠0) and absent from `cur` (modifier: bit clear; key: code not in any `cur` key slot). After index 11 → SCAN_PRS, index 0.
- SCAN_PRS: symmetric, push press of `cur` slot if present and absent from `prev`. A key code duplicated in `cur` pushes only for its lowest slot. After index 11 → COMMIT.
- COMMIT: `prev` ← `cur`; → IDLE.
- `usb_report` while not IDLE: ignored, `report_dropped` pulses that cycle.
- Releases always precede presses of the same report.
- FIFO push when full and no pop the same cycle: event discarded, `overflow` ← 1. Push while full with simultaneous pop: accepted.
- Pop on `ev_valid && ev_ready`; `ev_code`/`ev_press` stable while `ev_valid`=1 and not popped.

## Timing
- Reset values: FSM IDLE, `prev`/`cur` = 0, FIFO empty, `ev_valid`=0, `ev_code`=0, `ev_press`=0, `busy`=0, `report_dropped`=0, `overflow`=0.
- Report accepted at cycle T: SCAN_REL examines slot k at T+1+k, SCAN_PRS slot k at T+13+k, COMMIT at T+25, IDLE (`busy`=0) at T+26. Next report accepted from T+26.
- Push at cycle C into empty FIFO → `ev_valid`=1 at C+1. Earliest event: release of slot 0 → `ev_valid` at T+2; press of key1 → push T+21, `ev_valid` T+22.
- Throughput: 1 pop per cycle; FIFO count updates on the clock edge after push/pop.
- Async reset mid-scan: all state to reset values immediately; partially queued events lost; `prev` = 0, so next report yields presses for all held keys.

## Test plan
- Report {mod=0, key1=0x04} from empty, `ev_ready`=1 → one event {0x04, press}, `ev_valid` high at T+22 for 1 cycle; then report all-zero → {0x04, release} at T+10 (slot 8 at T+9).
- Report {mod=0x02, key1=0x04} → events in order {0xE1, press}, {0x04, press}; then {mod=0, key1=0x05} → {0xE1, rel}, {0x04, rel}, {0x05, press}.
- Report with key1=0x01 while holding 0x04 → no events, `prev` unchanged; later all-zero report → {0x04, release}.
- `FIFO_DEPTH`=8, `ev_ready`=0, report with mod=0xFF, keys 0x04..0x07 → 8 events stored (0xE0..0xE7), `overflow`=1; draining yields exactly those 8 in order.
- Holding {mod=0x01, key1=0x04}, `usb_type` → 0 → {0xE0, release}, {0x04, release}; second `usb_report` during scan → `report_dropped` pulse, no extra events.
- Assert `resetn`=0 at T+15 of a scan → outputs at reset values within the same cycle; after release, a report {key1=0x04} yields {0x04, press}.
